bp_fifo_loader_gen: RTL and testbench
=====================================

Name: bp_fifo_loader_gen

Overview:
Parametrised successor to the bias/param (BP) buffer loader. Requests one DDR burst and streams wide words from the DDR read FIFO into an X_MAC x X_MESH array of BP buffers. Lines fill successive bank groups, and the group index wraps modulo X_MAC. Adds over the previous loader: any line count, any start group, two address modes, backpressure-safe FIFO handshake, abort, a done pulse and config-error reporting.

Parameters:
X_MAC, 4, bank groups (buffers per mesh lane); must be a power of two, at least 2
X_MESH, 16, lanes per FIFO word
DATA_LEN, 32, bits per lane
ADDR_LEN, 16, buffer address width
DDR_ADDR_LEN, 32, DDR address width
SINGLE_LEN, 24, width of count and length fields
Derived (localparam): BUFFER_NUM = X_MAC*X_MESH; GW = clog2(X_MAC)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
conf  in  1  one-cycle start strobe; samples all cfg_* inputs
cfg_ddr_addr  in  DDR_ADDR_LEN  DDR burst start address
cfg_ddr_byte  in  SINGLE_LEN  DDR burst length in bytes, passed through unchecked
cfg_st_addr  in  ADDR_LEN  first buffer address
cfg_st_grp  in  GW  first bank group
cfg_line_width  in  SINGLE_LEN  words per line
cfg_line_num  in  SINGLE_LEN  number of lines
cfg_addr_mode  in  1  0: address restarts at cfg_st_addr every line; 1: address continues incrementing
abort  in  1  stop the transfer
ddr_st_addr_out  out  DDR_ADDR_LEN  latched burst address
ddr_len  out  SINGLE_LEN  latched burst length
ddr_conf  out  1  one-cycle burst request
ddr_fifo_empty  in  1  FIFO empty
ddr_fifo_req  out  1  FIFO pop (combinational)
ddr_fifo_data  in  DATA_LEN*X_MESH  FIFO read data, valid the cycle after a pop
buf_addr_out  out  ADDR_LEN*BUFFER_NUM  address broadcast to every buffer
buf_data_out  out  DATA_LEN*BUFFER_NUM  lane m drives buffers m*X_MAC+n for all n
buf_wea  out  BUFFER_NUM  write enables
idle  out  1  no transfer and no write pending
done  out  1  one-cycle completion pulse
cfg_err  out  1  one-cycle error pulse

Behaviour:
- Reset (async, any time, including mid-transfer): state IDLE, all counters zero; every output zero except idle=1.
- FSM states: IDLE, START, STREAM, DRAIN.
- IDLE + conf with width>0 and num>0:
  - latch all cfg_* inputs; go to START.
  - ddr_st_addr_out and ddr_len update on the cycle after conf and hold until the next accepted conf.
- IDLE + conf with width==0 or num==0: cfg_err=1 and done=1 on the next cycle; no ddr_conf; stay in IDLE.
- START: ddr_conf=1 for exactly one cycle; then STREAM.
- conf in any non-IDLE state: ignored; cfg_err pulses one cycle later.
- STREAM:
  - ddr_fifo_req = !ddr_fifo_empty && (pops < width*num) && !abort.
  - A pop is a cycle with req=1.
  - Pop at cycle t gives, at t+1: data registered to buf_data_out; buffer address and group registered; buf_wea[grp + X_MAC*m]=1 for all m in 0..X_MESH-1; every other wea bit 0.
  - Each pop increments the in-line count. At count==width-1 the count resets to 0 and the line index increments.
  - Group = (cfg_st_grp + line) mod X_MAC.
  - Address mode 0 reloads cfg_st_addr at each line start. Mode 1 increments by 1 on every pop. Both wrap modulo 2^ADDR_LEN.
  - After the final pop, go to DRAIN.
- DRAIN: the last write appears; done=1 on the cycle after the last wea; then IDLE.
- Empty bubbles: req=0 and wea=0 in the following cycle. No data is lost or duplicated.
- abort in STREAM or START:
  - req is forced low the same cycle.
  - A word popped in the previous cycle is still written.
  - Then IDLE with no done pulse.
  - An already-issued ddr_conf is not retracted; draining leftover FIFO data is the owner's responsibility.
- abort together with conf in IDLE: abort wins and the conf is dropped.
- idle = (state==IDLE) && no wea pending.
- Width, line-number and pop-count products are computed in 2*SINGLE_LEN bits; no truncation.

Test Plan:
1. X_MAC=4, X_MESH=16, st_addr=0x10, st_grp=0, width=3, num=2, mode 0, FIFO never empty -> ddr_conf pulse at conf+2; 6 pops; writes to addr 0x10,0x11,0x12 with wea bits {0,4,...,60}; then addr 0x10..0x12 with bits {1,5,...,61}; done one cycle after the 6th write.
2. st_grp=3, width=2, num=3, mode 1, st_addr=0xFFFE -> groups 3,0,1; addresses FFFE, FFFF, 0000, 0001, 0002, 0003.
3. empty toggling every other cycle, width=4, num=1 -> req never asserted while empty; exactly 4 writes carrying FIFO words in order; no wea in bubble cycles.
4. abort on the cycle after the 2nd pop, width=5, num=1 -> exactly 2 writes; no done; idle=1 two cycles later; a new conf is then accepted normally.
5. conf with width=0 -> cfg_err=1 and done=1 at conf+1; no ddr_conf; no req. A second conf during a running transfer -> cfg_err pulse; the transfer is unaffected.
6. rst_n asserted asynchronously mid-STREAM, between clock edges -> wea, req, ddr_conf and done go to 0 immediately; idle=1.

Source files
------------

// File: rtl/bp_fifo_loader_gen_if.sv
// Bus bundle for the BP buffer loader: controller config/start, DDR burst
// request, DDR read-FIFO handshake and the wide BP-buffer write port.
interface bp_fifo_loader_gen_if #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int DATA_LEN     = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DDR_ADDR_LEN = 32,
  parameter int SINGLE_LEN   = 24
);
  localparam int BUFFER_NUM = X_MAC * X_MESH;
  localparam int GW         = $clog2(X_MAC);

  // Controller side
  logic                         conf;
  logic [DDR_ADDR_LEN-1:0]      cfg_ddr_addr;
  logic [SINGLE_LEN-1:0]        cfg_ddr_byte;
  logic [ADDR_LEN-1:0]          cfg_st_addr;
  logic [GW-1:0]                cfg_st_grp;
  logic [SINGLE_LEN-1:0]        cfg_line_width;
  logic [SINGLE_LEN-1:0]        cfg_line_num;
  logic                         cfg_addr_mode;
  logic                         abort;
  logic                         idle;
  logic                         done;
  logic                         cfg_err;

  // DDR burst request
  logic [DDR_ADDR_LEN-1:0]      ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]        ddr_len;
  logic                         ddr_conf;

  // DDR read FIFO
  logic                         ddr_fifo_empty;
  logic                         ddr_fifo_req;
  logic [DATA_LEN*X_MESH-1:0]   ddr_fifo_data;

  // BP buffer write port
  logic [ADDR_LEN*BUFFER_NUM-1:0] buf_addr_out;
  logic [DATA_LEN*BUFFER_NUM-1:0] buf_data_out;
  logic [BUFFER_NUM-1:0]          buf_wea;

  modport master (
    output conf, cfg_ddr_addr, cfg_ddr_byte, cfg_st_addr, cfg_st_grp,
           cfg_line_width, cfg_line_num, cfg_addr_mode, abort,
           ddr_fifo_empty, ddr_fifo_data,
    input  idle, done, cfg_err, ddr_st_addr_out, ddr_len, ddr_conf,
           ddr_fifo_req, buf_addr_out, buf_data_out, buf_wea
  );

  modport slave (
    input  conf, cfg_ddr_addr, cfg_ddr_byte, cfg_st_addr, cfg_st_grp,
           cfg_line_width, cfg_line_num, cfg_addr_mode, abort,
           ddr_fifo_empty, ddr_fifo_data,
    output idle, done, cfg_err, ddr_st_addr_out, ddr_len, ddr_conf,
           ddr_fifo_req, buf_addr_out, buf_data_out, buf_wea
  );
endinterface

// File: rtl/bp_fifo_loader_gen.sv
// BP buffer loader: issues one DDR burst, then pops wide words from the DDR
// read FIFO and writes them into an X_MAC x X_MESH array of BP buffers.
// Successive lines land in successive bank groups (mod X_MAC).
module bp_fifo_loader_gen #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int DATA_LEN     = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DDR_ADDR_LEN = 32,
  parameter int SINGLE_LEN   = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bp_fifo_loader_gen_if.slave  bus
);
  localparam int BUFFER_NUM = X_MAC * X_MESH;
  localparam int GW         = $clog2(X_MAC);
  localparam int CW         = 2 * SINGLE_LEN;

  localparam logic [SINGLE_LEN-1:0] ONE_S = SINGLE_LEN'(1);
  localparam logic [CW-1:0]         ONE_C = CW'(1);
  localparam logic [ADDR_LEN-1:0]   ONE_A = ADDR_LEN'(1);
  localparam logic [GW-1:0]         ONE_G = GW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_DRAIN} state_e;

  state_e                  state_q;
  logic [DDR_ADDR_LEN-1:0] ddr_addr_q;
  logic [SINGLE_LEN-1:0]   ddr_len_q;
  logic                    ddr_conf_q;
  logic                    done_q;
  logic                    cfg_err_q;
  logic                    wea_q;
  logic [ADDR_LEN-1:0]     st_addr_q;
  logic [ADDR_LEN-1:0]     addr_cur_q;
  logic [ADDR_LEN-1:0]     addr_q;
  logic [GW-1:0]           grp_cur_q;
  logic [GW-1:0]           grp_q;
  logic                    mode_q;
  logic [SINGLE_LEN-1:0]   width_q;
  logic [SINGLE_LEN-1:0]   cnt_q;
  logic [CW-1:0]           total_q;
  logic [CW-1:0]           pops_q;

  logic                    cfg_ok;
  logic                    pop;
  logic                    line_end;
  logic                    last_pop;
  logic [CW-1:0]           total_d;
  logic [SINGLE_LEN-1:0]   cnt_d;
  logic [ADDR_LEN-1:0]     addr_d;
  logic [GW-1:0]           grp_d;
  logic [BUFFER_NUM-1:0]          wea_vec;
  logic [DATA_LEN*BUFFER_NUM-1:0] data_vec;

  // Pop decision and next values of the line counter, address and group.
  always_comb begin
    cfg_ok   = (bus.cfg_line_width != '0) && (bus.cfg_line_num != '0);
    total_d  = {{SINGLE_LEN{1'b0}}, bus.cfg_line_width} *
               {{SINGLE_LEN{1'b0}}, bus.cfg_line_num};
    pop      = (state_q == S_STREAM) && !bus.ddr_fifo_empty &&
               (pops_q < total_q) && !bus.abort;
    line_end = (cnt_q == width_q - ONE_S);
    last_pop = pop && ((pops_q + ONE_C) == total_q);
    cnt_d    = line_end ? '0 : cnt_q + ONE_S;
    // Mode 0 restarts each line at the start address; mode 1 keeps counting.
    addr_d   = (line_end && !mode_q) ? st_addr_q : addr_cur_q + ONE_A;
    // X_MAC is a power of two, so GW-bit wrap is exactly mod X_MAC.
    grp_d    = line_end ? grp_cur_q + ONE_G : grp_cur_q;
  end

  // Control FSM together with all registered outputs and the write stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ddr_addr_q <= '0;
      ddr_len_q  <= '0;
      ddr_conf_q <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      wea_q      <= 1'b0;
      st_addr_q  <= '0;
      addr_cur_q <= '0;
      addr_q     <= '0;
      grp_cur_q  <= '0;
      grp_q      <= '0;
      mode_q     <= 1'b0;
      width_q    <= '0;
      cnt_q      <= '0;
      total_q    <= '0;
      pops_q     <= '0;
    end else begin
      ddr_conf_q <= 1'b0;
      done_q     <= 1'b0;
      // A start strobe while busy is refused and flagged.
      cfg_err_q  <= bus.conf && (state_q != S_IDLE);
      wea_q      <= pop;
      if (pop) begin
        addr_q     <= addr_cur_q;
        grp_q      <= grp_cur_q;
        addr_cur_q <= addr_d;
        grp_cur_q  <= grp_d;
        cnt_q      <= cnt_d;
        pops_q     <= pops_q + ONE_C;
      end
      case (state_q)
        S_IDLE: begin
          // abort in the same cycle silently drops the start strobe
          if (bus.conf && !bus.abort) begin
            if (cfg_ok) begin
              ddr_addr_q <= bus.cfg_ddr_addr;
              ddr_len_q  <= bus.cfg_ddr_byte;
              st_addr_q  <= bus.cfg_st_addr;
              addr_cur_q <= bus.cfg_st_addr;
              grp_cur_q  <= bus.cfg_st_grp;
              mode_q     <= bus.cfg_addr_mode;
              width_q    <= bus.cfg_line_width;
              total_q    <= total_d;
              cnt_q      <= '0;
              pops_q     <= '0;
              state_q    <= S_START;
            end else begin
              cfg_err_q  <= 1'b1;
              done_q     <= 1'b1;
            end
          end
        end
        S_START: begin
          if (bus.abort) begin
            state_q    <= S_IDLE;
          end else begin
            ddr_conf_q <= 1'b1;
            state_q    <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
          end else if (last_pop) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // the final write is visible this cycle; completion follows it
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Fan the FIFO word out to the buffers: lane m feeds buffers m*X_MAC+n,
  // and only the active group's buffers are write-enabled.
  always_comb begin
    wea_vec  = '0;
    data_vec = '0;
    for (int m = 0; m < X_MESH; m++) begin
      if (wea_q) wea_vec[X_MAC*m + int'(grp_q)] = 1'b1;
      for (int n = 0; n < X_MAC; n++) begin
        data_vec[(m*X_MAC+n)*DATA_LEN +: DATA_LEN] =
          wea_q ? bus.ddr_fifo_data[m*DATA_LEN +: DATA_LEN] : '0;
      end
    end
  end

  assign bus.ddr_st_addr_out = ddr_addr_q;
  assign bus.ddr_len         = ddr_len_q;
  assign bus.ddr_conf        = ddr_conf_q;
  assign bus.ddr_fifo_req    = pop;
  assign bus.buf_addr_out    = {BUFFER_NUM{addr_q}};
  assign bus.buf_data_out    = data_vec;
  assign bus.buf_wea         = wea_vec;
  assign bus.idle            = (state_q == S_IDLE) && !wea_q;
  assign bus.done            = done_q;
  assign bus.cfg_err         = cfg_err_q;
endmodule

// File: tb/tb_bp_fifo_loader_gen.sv
// Bench for bp_fifo_loader_gen: a FIFO model feeds random words, a reference
// model computes the expected write list, and a monitor scoreboards writes.
module tb_bp_fifo_loader_gen;
  localparam int X_MAC    = 4;
  localparam int X_MESH   = 16;
  localparam int DATA_LEN = 32;
  localparam int ADDR_LEN = 16;
  localparam int SL       = 24;
  localparam int GW       = 2;
  localparam int BN       = X_MAC * X_MESH;
  localparam int WW       = DATA_LEN * X_MESH;
  localparam int DW       = DATA_LEN * BN;

  typedef struct {
    logic [ADDR_LEN-1:0] addr;
    int                  grp;
    logic [WW-1:0]       data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t          exp_q[$];
  logic [WW-1:0] fifo_q[$];
  int            empty_mode = 0;

  int wr_cnt = 0, last_wr_cyc = 0;
  int done_cnt = 0, done_cyc = 0;
  int ddr_conf_cnt = 0, ddr_conf_cyc = 0;
  int cfg_err_cnt = 0;
  int pop_cnt = 0, req_empty_err = 0;

  int conf_cyc, d0, dc0, wr0, ce0, p0, cur_total;
  logic [31:0] cur_ddr_addr;
  logic [SL-1:0] cur_ddr_len;

  bp_fifo_loader_gen_if bus ();

  bp_fifo_loader_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < X_MESH; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int idx;
    checks++;
    if (act !== exp) begin
      idx = 0;
      for (int i = DW/32-1; i >= 0; i--) if (act[i*32 +: 32] !== exp[i*32 +: 32]) idx = i;
      errors++;
      $display("FAIL %s: word %0d got %h expected %h (cycle %0d)", nm, idx,
               act[idx*32 +: 32], exp[idx*32 +: 32], cyc);
    end
  endtask

  // FIFO model: pops on req, presents the popped word the following cycle.
  initial begin : fifo_model
    logic [WW-1:0] w;
    bit popped;
    bit tog;
    bit e;
    tog = 1'b0;
    w = '0;
    bus.ddr_fifo_empty = 1'b1;
    bus.ddr_fifo_data  = '0;
    forever begin
      @(negedge clk);
      popped = 1'b0;
      if (rst_n && bus.ddr_fifo_req) begin
        pop_cnt++;
        if (bus.ddr_fifo_empty) req_empty_err++;
        if (fifo_q.size() > 0) begin
          w = fifo_q.pop_front();
          popped = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      bus.ddr_fifo_data = popped ? w : rand_word();
      tog = ~tog;
      case (empty_mode)
        0:       e = 1'b0;
        1:       e = tog;
        default: e = ($urandom_range(0, 2) == 0);
      endcase
      bus.ddr_fifo_empty = (fifo_q.size() == 0) || e;
    end
  end

  // Monitor: event bookkeeping and write scoreboard.
  initial begin : monitor
    exp_t e;
    logic [63:0] ew;
    logic [DW-1:0] ea, ed;
    forever begin
      @(negedge clk);
      if (bus.ddr_conf) begin ddr_conf_cnt++; ddr_conf_cyc = cyc; end
      if (bus.done)     begin done_cnt++;     done_cyc = cyc;     end
      if (bus.cfg_err)  cfg_err_cnt++;
      if (bus.buf_wea != '0) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: wea %h with no write outstanding (cycle %0d)",
                   bus.buf_wea, cyc);
        end else begin
          e  = exp_q.pop_front();
          ew = '0;
          ea = '0;
          ed = '0;
          for (int m = 0; m < X_MESH; m++) ew[e.grp + X_MAC*m] = 1'b1;
          for (int b = 0; b < BN; b++) ea[b*ADDR_LEN +: ADDR_LEN] = e.addr;
          for (int m = 0; m < X_MESH; m++)
            for (int n = 0; n < X_MAC; n++)
              ed[(m*X_MAC+n)*DATA_LEN +: DATA_LEN] = e.data[m*DATA_LEN +: DATA_LEN];
          chk("wea", bus.buf_wea, ew);
          chk_wide("addr", DW'(bus.buf_addr_out), ea);
          chk_wide("data", bus.buf_data_out, ed);
        end
      end
    end
  end

  task automatic scramble_cfg();
    bus.cfg_ddr_addr   = $urandom;
    bus.cfg_ddr_byte   = SL'($urandom);
    bus.cfg_st_addr    = ADDR_LEN'($urandom);
    bus.cfg_st_grp     = GW'($urandom);
    bus.cfg_line_width = SL'($urandom_range(1, 9));
    bus.cfg_line_num   = SL'($urandom_range(1, 9));
    bus.cfg_addr_mode  = 1'($urandom);
  endtask

  // Reference model: write i goes to line i/w, position i%w.
  task automatic start_xfer(input logic [ADDR_LEN-1:0] sa, input int grp, input int w,
                            input int n, input bit mode, input int em);
    logic [WW-1:0] word;
    exp_t e;
    empty_mode = em;
    cur_total  = w * n;
    for (int i = 0; i < cur_total; i++) begin
      word = rand_word();
      fifo_q.push_back(word);
      e.grp  = (grp + i / w) % X_MAC;
      e.addr = mode ? ADDR_LEN'(int'(sa) + i) : ADDR_LEN'(int'(sa) + i % w);
      e.data = word;
      exp_q.push_back(e);
    end
    cur_ddr_addr = $urandom;
    cur_ddr_len  = SL'($urandom);
    @(posedge clk);
    #1;
    bus.conf           = 1'b1;
    bus.cfg_ddr_addr   = cur_ddr_addr;
    bus.cfg_ddr_byte   = cur_ddr_len;
    bus.cfg_st_addr    = sa;
    bus.cfg_st_grp     = GW'(grp);
    bus.cfg_line_width = SL'(w);
    bus.cfg_line_num   = SL'(n);
    bus.cfg_addr_mode  = mode;
    conf_cyc = cyc;
    d0  = done_cnt;
    dc0 = ddr_conf_cnt;
    wr0 = wr_cnt;
    ce0 = cfg_err_cnt;
    p0  = pop_cnt;
    @(posedge clk);
    #1;
    bus.conf = 1'b0;
    scramble_cfg();
  endtask

  task automatic finish_xfer(input string tag, input int exp_err);
    for (int k = 0; k < 20*cur_total + 50 && done_cnt == d0; k++) @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_ddr_conf_pulses"}, 64'(ddr_conf_cnt - dc0), 64'd1);
    chk({tag, "_ddr_conf_latency"}, 64'(ddr_conf_cyc - conf_cyc), 64'd2);
    chk({tag, "_writes"}, 64'(wr_cnt - wr0), 64'(cur_total));
    chk({tag, "_done_after_last_write"}, 64'(done_cyc - last_wr_cyc), 64'd1);
    chk({tag, "_writes_outstanding"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_ddr_st_addr_out"}, 64'(bus.ddr_st_addr_out), 64'(cur_ddr_addr));
    chk({tag, "_ddr_len"}, 64'(bus.ddr_len), 64'(cur_ddr_len));
    chk({tag, "_req_while_empty"}, 64'(req_empty_err), 64'd0);
    chk({tag, "_cfg_err_pulses"}, 64'(cfg_err_cnt - ce0), 64'(exp_err));
    chk({tag, "_idle_after"}, 64'(bus.idle), 64'd1);
  endtask

  task automatic bad_conf(input string tag, input int w, input int n);
    int dcs, ps;
    dcs = ddr_conf_cnt;
    ps  = pop_cnt;
    @(posedge clk);
    #1;
    bus.conf           = 1'b1;
    bus.cfg_line_width = SL'(w);
    bus.cfg_line_num   = SL'(n);
    @(posedge clk);
    #1;
    bus.conf = 1'b0;
    scramble_cfg();
    @(negedge clk);
    chk({tag, "_cfg_err"}, 64'(bus.cfg_err), 64'd1);
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    repeat (5) @(negedge clk);
    chk({tag, "_no_ddr_conf"}, 64'(ddr_conf_cnt - dcs), 64'd0);
    chk({tag, "_no_req"}, 64'(pop_cnt - ps), 64'd0);
    chk({tag, "_idle"}, 64'(bus.idle), 64'd1);
  endtask

  initial begin : main
    int ws, ns, dcs, ces, cc;
    logic [ADDR_LEN-1:0] sa;
    bus.conf  = 1'b0;
    bus.abort = 1'b0;
    scramble_cfg();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    chk("rst_wea", bus.buf_wea, 64'd0);
    chk("rst_req", 64'(bus.ddr_fifo_req), 64'd0);
    chk("rst_ddr_conf", 64'(bus.ddr_conf), 64'd0);
    chk("rst_done_err", 64'({bus.done, bus.cfg_err}), 64'd0);
    chk("rst_ddr_addr_len", 64'({bus.ddr_st_addr_out, bus.ddr_len}), 64'd0);
    chk_wide("rst_buf_addr", DW'(bus.buf_addr_out), '0);
    chk_wide("rst_buf_data", bus.buf_data_out, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Mode 0, two lines from group 0
    start_xfer(16'h0010, 0, 3, 2, 1'b0, 0);
    finish_xfer("t1", 0);

    // Mode 1 with address wrap, groups 3,0,1
    start_xfer(16'hFFFE, 3, 2, 3, 1'b1, 0);
    finish_xfer("t2", 0);

    // Empty toggling every other cycle
    start_xfer(16'h0100, 1, 4, 1, 1'b0, 1);
    finish_xfer("t3", 0);

    // Abort on the cycle after the second pop
    start_xfer(16'h0200, 2, 5, 1, 1'b0, 0);
    for (int k = 0; k < 50 && pop_cnt < p0 + 2; k++) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_idle", 64'(bus.idle), 64'd1);
    repeat (10) @(negedge clk);
    chk("t4_writes", 64'(wr_cnt - wr0), 64'd2);
    chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t4_left_in_model", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    fifo_q.delete();
    start_xfer(16'h0300, 1, 2, 2, 1'b1, 0);
    finish_xfer("t4_after", 0);

    // Abort together with conf in IDLE drops the conf
    dcs = ddr_conf_cnt;
    ces = cfg_err_cnt;
    @(posedge clk);
    #1;
    bus.conf = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.conf = 1'b0;
    bus.abort = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_conf_no_ddr_conf", 64'(ddr_conf_cnt - dcs), 64'd0);
    chk("abort_conf_no_cfg_err", 64'(cfg_err_cnt - ces), 64'd0);
    chk("abort_conf_idle", 64'(bus.idle), 64'd1);

    // Zero width / zero line count
    bad_conf("t5_w0", 0, 3);
    bad_conf("t5_n0", 4, 0);

    // Second conf while busy
    start_xfer(16'h0400, 2, 4, 2, 1'b0, 0);
    for (int k = 0; k < 50 && pop_cnt < p0 + 1; k++) @(posedge clk);
    #1;
    bus.conf = 1'b1;
    bus.cfg_line_width = SL'(7);
    bus.cfg_line_num   = SL'(7);
    cc = cyc;
    @(posedge clk);
    #1 bus.conf = 1'b0;
    @(negedge clk);
    chk("t5_busy_cfg_err", 64'(bus.cfg_err), 64'd1);
    chk("t5_busy_cfg_err_cycle", 64'(cyc - cc), 64'd1);
    finish_xfer("t5_busy", 1);

    // Asynchronous reset mid-stream, between clock edges
    start_xfer(16'h0500, 0, 20, 2, 1'b1, 2);
    for (int k = 0; k < 200 && pop_cnt < p0 + 5; k++) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_wea", bus.buf_wea, 64'd0);
    chk("t6_req", 64'(bus.ddr_fifo_req), 64'd0);
    chk("t6_ddr_conf_done", 64'({bus.ddr_conf, bus.done}), 64'd0);
    chk("t6_idle", 64'(bus.idle), 64'd1);
    chk_wide("t6_data", bus.buf_data_out, '0);
    exp_q.delete();
    fifo_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Random transfers
    for (int r = 0; r < 6; r++) begin
      ws = $urandom_range(1, 5);
      ns = $urandom_range(1, 5);
      sa = ($urandom_range(0, 1) == 1) ? ADDR_LEN'(16'hFFF0 + $urandom_range(0, 15))
                                        : ADDR_LEN'($urandom);
      start_xfer(sa, $urandom_range(0, 3), ws, ns, 1'($urandom), $urandom_range(0, 2));
      finish_xfer("rand", 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
